// File: rtl/home_event_scheduler.sv
// Arbitrates N level-sensitive sensor channels plus one hysteretic thermostat
// channel and drives one actuator at a time for a fixed dwell.
module home_event_scheduler #(
  parameter int NUM_SENSORS   = 5,
  parameter int TEMP_WIDTH    = 6,
  parameter int HEAT_ON       = 15,
  parameter int COOL_ON       = 30,
  parameter int HYST          = 2,
  parameter int DWELL         = 4,
  parameter int PRIORITY_MODE = 0,
  localparam int DISP_W       = $clog2(NUM_SENSORS + 3)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SENSORS-1:0] sensor_in,
  input  logic [TEMP_WIDTH-1:0]  temperature,
  output logic [NUM_SENSORS-1:0] act,
  output logic                   heater,
  output logic                   cooler,
  output logic [DISP_W-1:0]      display,
  output logic                   busy
);

  localparam int SLOTS = NUM_SENSORS + 1;
  localparam int PTR_W = $clog2(SLOTS);
  localparam int CNT_W = $clog2(DWELL + 1);

  // Handshake: none. Sensors are level requests sampled every cycle in SCAN;
  // a grant is never withdrawn early, so no ready/ack path exists.
  typedef enum logic {SCAN, HOLD} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   ptr, ptr_nxt, grant, grant_nxt, win;
  logic               win_valid;
  logic [CNT_W-1:0]   dwell_cnt, dwell_nxt;
  logic               heat_st, cool_st, heat_nxt, cool_nxt;
  logic [SLOTS-1:0]   req;
  logic [31:0]        temp_u;

  logic [NUM_SENSORS-1:0] act_nxt;
  logic                   heater_nxt, cooler_nxt, busy_nxt;
  logic [DISP_W-1:0]      display_nxt;

  assign temp_u = 32'(temperature);
  assign req    = {heat_st | cool_st, sensor_in};

  // Set/clear thresholds are separated by the hysteresis band; inside it the state holds.
  always_comb begin
    heat_nxt = heat_st;
    cool_nxt = cool_st;
    if (temp_u < 32'(HEAT_ON))             heat_nxt = 1'b1;
    else if (temp_u >= 32'(HEAT_ON + HYST)) heat_nxt = 1'b0;
    if (temp_u > 32'(COOL_ON))             cool_nxt = 1'b1;
    else if (temp_u <= 32'(COOL_ON - HYST)) cool_nxt = 1'b0;
  end

  // Winner search: rotating start at ptr (wrapping at SLOTS) or fixed from slot 0.
  always_comb begin
    int idx;
    idx       = 0;
    win       = '0;
    win_valid = 1'b0;
    for (int k = 0; k < SLOTS; k++) begin
      if (PRIORITY_MODE != 0) idx = k;
      else begin
        idx = int'(ptr) + k;
        if (idx >= SLOTS) idx = idx - SLOTS;
      end
      if (!win_valid && req[idx]) begin
        win_valid = 1'b1;
        win       = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    grant_nxt   = grant;
    dwell_nxt   = dwell_cnt;
    act_nxt     = act;
    heater_nxt  = heater;
    cooler_nxt  = cooler;
    display_nxt = display;
    busy_nxt    = busy;
    case (state)
      SCAN: begin
        act_nxt     = '0;
        heater_nxt  = 1'b0;
        cooler_nxt  = 1'b0;
        display_nxt = '0;
        busy_nxt    = 1'b0;
        if (win_valid) begin
          state_nxt = HOLD;
          busy_nxt  = 1'b1;
          dwell_nxt = CNT_W'(DWELL - 1);
          grant_nxt = win;
          if (win == PTR_W'(NUM_SENSORS)) begin
            // Heat/cool choice is frozen here for the whole hold.
            heater_nxt  = heat_st;
            cooler_nxt  = !heat_st;
            display_nxt = heat_st ? DISP_W'(NUM_SENSORS + 1) : DISP_W'(NUM_SENSORS + 2);
          end else begin
            act_nxt     = NUM_SENSORS'(1) << win;
            display_nxt = DISP_W'(win) + 1'b1;
          end
        end
      end
      HOLD: begin
        if (dwell_cnt == '0) begin
          state_nxt   = SCAN;
          act_nxt     = '0;
          heater_nxt  = 1'b0;
          cooler_nxt  = 1'b0;
          display_nxt = '0;
          busy_nxt    = 1'b0;
          ptr_nxt     = (grant == PTR_W'(NUM_SENSORS)) ? '0 : grant + 1'b1;
        end else begin
          dwell_nxt = dwell_cnt - 1'b1;
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      ptr       <= '0;
      grant     <= '0;
      dwell_cnt <= '0;
      heat_st   <= 1'b0;
      cool_st   <= 1'b0;
      act       <= '0;
      heater    <= 1'b0;
      cooler    <= 1'b0;
      display   <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      grant     <= grant_nxt;
      dwell_cnt <= dwell_nxt;
      heat_st   <= heat_nxt;
      cool_st   <= cool_nxt;
      act       <= act_nxt;
      heater    <= heater_nxt;
      cooler    <= cooler_nxt;
      display   <= display_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule
